// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch stage and its BTB/bimodal predictor.
package fetch_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    function automatic int calc_idx(input int entries);
        return $clog2(entries);
    endfunction

    // Two-bit saturating counter step toward the resolved direction.
    function automatic ctr_t ctr_train(input ctr_t c, input logic taken);
        case (c)
            SNT:     return taken ? WNT : SNT;
            WNT:     return taken ? WT  : SNT;
            WT:      return taken ? ST  : WNT;
            ST:      return taken ? ST  : WT;
            default: return WNT;
        endcase
    endfunction

    function automatic logic ctr_predicts_taken(input ctr_t c);
        return (c == WT) || (c == ST);
    endfunction

endpackage

// File: rtl/btb_bimodal.sv
// Direct-mapped BTB with a 2-bit bimodal counter per entry: combinational
// lookup port and a synchronous train/allocate port.
module btb_bimodal
    import fetch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken,
    output logic [XLEN-1:0] lookup_target,
    input  logic            update_en,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target
);

    localparam int IDX   = calc_idx(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    logic             valid_q  [ENTRIES];
    ctr_t             ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];

    logic [IDX-1:0]   l_idx;
    logic [IDX-1:0]   u_idx;
    logic [TAG_W-1:0] l_tag;
    logic [TAG_W-1:0] u_tag;
    logic             l_hit;
    logic             u_hit;
    logic             unused_pc_bits;

    assign l_idx = lookup_pc[IDX+1:2];
    assign l_tag = lookup_pc[XLEN-1:IDX+2];
    assign u_idx = update_pc[IDX+1:2];
    assign u_tag = update_pc[XLEN-1:IDX+2];

    // Word-aligned fetch: the byte offset never participates in index or tag.
    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    assign l_hit         = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign lookup_taken  = l_hit && ctr_predicts_taken(ctr_q[l_idx]);
    assign lookup_target = target_q[l_idx];

    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // NOTE: non-blocking assignments so every reader of this state in the same
    // cycle sees the pre-edge value; a same-cycle lookup never sees the update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WNT;
            end
        end else if (update_en) begin
            if (u_hit) begin
                ctr_q[u_idx] <= ctr_train(ctr_q[u_idx], update_taken);
            end else if (update_taken) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= WT;
            end
        end
    end

    // NOTE: tag/target arrays are plain storage qualified by valid_q, so they
    // are deliberately left out of reset; only the control bits need clearing.
    always_ff @(posedge clk) begin
        if (!rst && update_en && update_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= update_target;
        end
    end

endmodule

// File: rtl/fetch_bpred.sv
// Instruction-fetch stage: next-PC selection with BTB/bimodal prediction and
// the IF/ID pipeline register.
module fetch_bpred
    import fetch_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}},
    parameter logic [31:0]     NOP_INSTR   = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            flush_d,
    input  logic            redirect_e,
    input  logic [XLEN-1:0] redirect_pc_e,
    input  logic            update_e,
    input  logic [XLEN-1:0] update_pc_e,
    input  logic            update_taken_e,
    input  logic [XLEN-1:0] update_target_e,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            pred_taken_d,
    output logic [XLEN-1:0] pred_target_d,
    output logic            valid_d
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] pred_next;
    logic [XLEN-1:0] btb_target;
    logic            pred_taken_f;

    assign imem_addr  = pc_q;
    assign pc_plus4_f = pc_q + XLEN'(4);

    btb_bimodal #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .lookup_pc     (pc_q),
        .lookup_taken  (pred_taken_f),
        .lookup_target (btb_target),
        .update_en     (update_e),
        .update_pc     (update_pc_e),
        .update_taken  (update_taken_e),
        .update_target (update_target_e)
    );

    assign pred_next = pred_taken_f ? btb_target : pc_plus4_f;

    // NOTE: pc_next gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_next = pred_next;
        if (redirect_e) begin
            pc_next = redirect_pc_e;
        end else if (stall_f) begin
            pc_next = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    // A bubble only clears the fields decode acts on; the PC fields keep
    // whatever they held since valid_d=0 marks them as meaningless.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_d       <= NOP_INSTR;
            pc_d          <= '0;
            pc_plus4_d    <= '0;
            pred_taken_d  <= 1'b0;
            pred_target_d <= '0;
            valid_d       <= 1'b0;
        end else if (redirect_e || flush_d) begin
            instr_d      <= NOP_INSTR;
            pred_taken_d <= 1'b0;
            valid_d      <= 1'b0;
        end else if (!stall_f) begin
            instr_d       <= imem_rdata;
            pc_d          <= pc_q;
            pc_plus4_d    <= pc_plus4_f;
            pred_taken_d  <= pred_taken_f;
            pred_target_d <= pred_next;
            valid_d       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_bpred.sv
// Scoreboard bench for fetch_bpred: the driver queues the expected post-edge
// state for each cycle and a monitor compares it one step after the edge.
module tb_fetch_bpred;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {K_RST, K_BUB, K_LOAD} kind_t;

    typedef struct packed {
        logic [15:0] id;
        kind_t       kind;
        logic [31:0] pc_f;
        logic [31:0] pcd;
        logic        pt;
        logic [31:0] ptgt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   step_id = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        flush_d;
    logic        redirect_e;
    logic [31:0] redirect_pc_e;
    logic        update_e;
    logic [31:0] update_pc_e;
    logic        update_taken_e;
    logic [31:0] update_target_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        pred_taken_d;
    logic [31:0] pred_target_d;
    logic        valid_d;

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = pat(imem_addr);

    fetch_bpred dut (
        .clk             (clk),
        .rst             (rst),
        .stall_f         (stall_f),
        .flush_d         (flush_d),
        .redirect_e      (redirect_e),
        .redirect_pc_e   (redirect_pc_e),
        .update_e        (update_e),
        .update_pc_e     (update_pc_e),
        .update_taken_e  (update_taken_e),
        .update_target_e (update_target_e),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .instr_d         (instr_d),
        .pc_d            (pc_d),
        .pc_plus4_d      (pc_plus4_d),
        .pred_taken_d    (pred_taken_d),
        .pred_target_d   (pred_target_d),
        .valid_d         (valid_d)
    );

    task automatic check(input int id, input string fld, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL step%0d %s: got %h want %h", id, fld, act, exp);
        end
    endtask

    // Monitor: one queued expectation is retired just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(int'(e.id), "pc_f", imem_addr, e.pc_f);
                case (e.kind)
                    K_RST: begin
                        check(int'(e.id), "instr_d", instr_d, NOP);
                        check(int'(e.id), "valid_d", 32'(valid_d), 32'd0);
                        check(int'(e.id), "pred_taken_d", 32'(pred_taken_d), 32'd0);
                        check(int'(e.id), "pc_d", pc_d, 32'd0);
                        check(int'(e.id), "pc_plus4_d", pc_plus4_d, 32'd0);
                        check(int'(e.id), "pred_target_d", pred_target_d, 32'd0);
                    end
                    K_BUB: begin
                        check(int'(e.id), "instr_d", instr_d, NOP);
                        check(int'(e.id), "valid_d", 32'(valid_d), 32'd0);
                        check(int'(e.id), "pred_taken_d", 32'(pred_taken_d), 32'd0);
                    end
                    default: begin
                        check(int'(e.id), "instr_d", instr_d, pat(e.pcd));
                        check(int'(e.id), "valid_d", 32'(valid_d), 32'd1);
                        check(int'(e.id), "pc_d", pc_d, e.pcd);
                        check(int'(e.id), "pc_plus4_d", pc_plus4_d, e.pcd + 32'd4);
                        check(int'(e.id), "pred_taken_d", 32'(pred_taken_d), 32'(e.pt));
                        check(int'(e.id), "pred_target_d", pred_target_d, e.ptgt);
                    end
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, %0d expectations pending, want 0", sb.size());
        $fatal(1, "watchdog");
    end

    task automatic step(input kind_t k, input logic [31:0] pcf, input logic [31:0] pcd,
                        input logic pt, input logic [31:0] ptgt);
        exp_t e;
        e.id   = 16'(step_id);
        e.kind = k;
        e.pc_f = pcf;
        e.pcd  = pcd;
        e.pt   = pt;
        e.ptgt = ptgt;
        sb.push_back(e);
        step_id++;
        @(negedge clk);
        rst            = 1'b0;
        stall_f        = 1'b0;
        flush_d        = 1'b0;
        redirect_e     = 1'b0;
        update_e       = 1'b0;
        update_taken_e = 1'b0;
    endtask

    task automatic ld(input logic [31:0] pcf, input logic [31:0] pcd, input logic pt,
                      input logic [31:0] ptgt);
        step(K_LOAD, pcf, pcd, pt, ptgt);
    endtask

    task automatic bub(input logic [31:0] pcf);
        step(K_BUB, pcf, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        update_e        = 1'b1;
        update_pc_e     = pc;
        update_taken_e  = taken;
        update_target_e = tgt;
    endtask

    task automatic redir(input logic [31:0] pc);
        redirect_e    = 1'b1;
        redirect_pc_e = pc;
    endtask

    initial begin
        rst             = 1'b1;
        stall_f         = 1'b0;
        flush_d         = 1'b0;
        redirect_e      = 1'b0;
        redirect_pc_e   = 32'd0;
        update_e        = 1'b0;
        update_pc_e     = 32'd0;
        update_taken_e  = 1'b0;
        update_target_e = 32'd0;
        @(negedge clk);

        // Reset, then sequential fetch with no predictor state.
        rst = 1'b1;
        step(K_RST, 32'd0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) ld(32'(4*i+4), 32'(4*i), 1'b0, 32'(4*i+4));

        // Allocate 0x10 -> 0x40 (counter WT) and fetch it.
        upd(32'h10, 1'b1, 32'h40); ld(32'h1C, 32'h18, 1'b0, 32'h1C);
        redir(32'h10);             bub(32'h10);
        ld(32'h40, 32'h10, 1'b1, 32'h40);
        ld(32'h44, 32'h40, 1'b0, 32'h44);

        // Hysteresis: WT -> WNT, then up to ST and saturate with a new target.
        upd(32'h10, 1'b0, 32'h0);  redir(32'h10); bub(32'h10);
        ld(32'h14, 32'h10, 1'b0, 32'h14);
        upd(32'h10, 1'b1, 32'h40); ld(32'h18, 32'h14, 1'b0, 32'h18);
        upd(32'h10, 1'b1, 32'h40); ld(32'h1C, 32'h18, 1'b0, 32'h1C);
        upd(32'h10, 1'b1, 32'h80); redir(32'h10); bub(32'h10);
        // Same-cycle training sees old ST; afterwards WT, then WNT.
        upd(32'h10, 1'b0, 32'h0);  ld(32'h80, 32'h10, 1'b1, 32'h80);
        redir(32'h10);             bub(32'h10);
        upd(32'h10, 1'b0, 32'h0);  ld(32'h80, 32'h10, 1'b1, 32'h80);
        redir(32'h10);             bub(32'h10);
        ld(32'h14, 32'h10, 1'b0, 32'h14);

        // Alias 0x50 shares index 4 with 0x10 but not the tag.
        upd(32'h10, 1'b1, 32'h80); ld(32'h18, 32'h14, 1'b0, 32'h18);
        redir(32'h50);             bub(32'h50);
        ld(32'h54, 32'h50, 1'b0, 32'h54);
        upd(32'h50, 1'b1, 32'h100); redir(32'h10); bub(32'h10);
        ld(32'h14, 32'h10, 1'b0, 32'h14);
        redir(32'h50);             bub(32'h50);
        ld(32'h100, 32'h50, 1'b1, 32'h100);
        upd(32'h10, 1'b0, 32'h0);  redir(32'h50); bub(32'h50);
        ld(32'h100, 32'h50, 1'b1, 32'h100);

        // Stall holds PC and IF/ID; redirect and flush both beat stall.
        for (int i = 0; i < 3; i++) begin
            stall_f = 1'b1;
            ld(32'h100, 32'h50, 1'b1, 32'h100);
        end
        stall_f = 1'b1; redir(32'h200); bub(32'h200);
        stall_f = 1'b1; flush_d = 1'b1; bub(32'h200);
        ld(32'h204, 32'h200, 1'b0, 32'h204);
        flush_d = 1'b1; bub(32'h208);
        ld(32'h20C, 32'h208, 1'b0, 32'h20C);

        // PC+4 wraps at 2^32.
        redir(32'hFFFF_FFFC); bub(32'hFFFF_FFFC);
        ld(32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Mid-run reset overrides redirect/update and clears the BTB.
        upd(32'h10, 1'b1, 32'h40); ld(32'h4, 32'h0, 1'b0, 32'h4);
        rst = 1'b1; redir(32'h300); upd(32'h8, 1'b1, 32'h60);
        step(K_RST, 32'd0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) ld(32'(4*i+4), 32'(4*i), 1'b0, 32'(4*i+4));

        @(negedge clk);
        check(step_id, "queue_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
